// File: rtl/funct_generator_pkg.sv
// Shared types, default widths and the phase-to-address helper for the function-generator sequencer.
package funct_generator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fgen_state_t;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_PHASE_WIDTH = 16;
  localparam int DEF_COUNT_WIDTH = 16;

  // LUT address is the top addr_w bits of the phase accumulator; caller truncates to addr_w.
  function automatic logic [63:0] fgen_acc_addr(input logic [63:0] acc, input int phase_w,
                                                input int addr_w);
    return acc >> (phase_w - addr_w);
  endfunction

endpackage

// File: rtl/funct_generator_seq_if.sv
// Control, LUT read and FIFO write signals of the sequencer.
// FUNCT_GEN_AMP_SCALE_EN adds the amp_shift_i amplitude-scaling input.
interface funct_generator_seq_if #(
  parameter int DATA_WIDTH  = funct_generator_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = funct_generator_pkg::DEF_ADDR_WIDTH,
  parameter int PHASE_WIDTH = funct_generator_pkg::DEF_PHASE_WIDTH,
  parameter int COUNT_WIDTH = funct_generator_pkg::DEF_COUNT_WIDTH
);
  logic                   start_i;
  logic                   stop_i;
  logic [PHASE_WIDTH-1:0] freq_word_i;
  logic [COUNT_WIDTH-1:0] num_samples_i;
  logic [ADDR_WIDTH-1:0]  read_addr_o;
  logic [DATA_WIDTH-1:0]  read_data_i;
  logic                   full_i;
  logic                   wr_en_o;
  logic [DATA_WIDTH-1:0]  wr_data_o;
  logic                   busy_o;
  logic                   done_o;

`ifdef FUNCT_GEN_AMP_SCALE_EN
  logic [4:0]             amp_shift_i;

  modport master (
    output start_i, stop_i, freq_word_i, num_samples_i, read_data_i, full_i, amp_shift_i,
    input  read_addr_o, wr_en_o, wr_data_o, busy_o, done_o
  );
  modport slave (
    input  start_i, stop_i, freq_word_i, num_samples_i, read_data_i, full_i, amp_shift_i,
    output read_addr_o, wr_en_o, wr_data_o, busy_o, done_o
  );
`else
  modport master (
    output start_i, stop_i, freq_word_i, num_samples_i, read_data_i, full_i,
    input  read_addr_o, wr_en_o, wr_data_o, busy_o, done_o
  );
  modport slave (
    input  start_i, stop_i, freq_word_i, num_samples_i, read_data_i, full_i,
    output read_addr_o, wr_en_o, wr_data_o, busy_o, done_o
  );
`endif

endinterface

// File: rtl/funct_generator_phase_acc.sv
// Phase accumulator with clear/advance controls; wraps silently modulo 2**PHASE_WIDTH.
module funct_generator_phase_acc
  import funct_generator_pkg::*;
#(
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_advance,
  input  logic [PHASE_WIDTH-1:0] i_freq_word,
  output logic [ADDR_WIDTH-1:0]  o_addr
);

  logic [PHASE_WIDTH-1:0] r_acc;

  // Accumulator: cleared on burst start, stepped by the tuning word on each advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_advance) begin
      r_acc <= r_acc + i_freq_word;
    end
  end

  assign o_addr = ADDR_WIDTH'(fgen_acc_addr(64'(r_acc), PHASE_WIDTH, ADDR_WIDTH));

endmodule

// File: rtl/funct_generator_seq.sv
// Phase-accumulator sequencer: walks the LUT, replays the stalled address under FIFO backpressure.
// FUNCT_GEN_AMP_SCALE_EN enables arithmetic right-shift amplitude scaling of pushed samples.
module funct_generator_seq
  import funct_generator_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  funct_generator_seq_if.slave bus
);

  fgen_state_t                   r_state;
  logic                          r_issued;
  logic                          r_done;
  logic [ADDR_WIDTH-1:0]         r_prev_addr;
  logic [COUNT_WIDTH-1:0]        r_issue_cnt;
  logic [COUNT_WIDTH-1:0]        r_num;

  logic [ADDR_WIDTH-1:0]         w_acc_addr;
  logic                          w_stall;
  logic                          w_push;
  logic                          w_advance;
  logic                          w_clear;
  logic                          w_last_issue;
  logic signed [DATA_WIDTH-1:0]  w_sample;

  assign w_stall      = r_issued & bus.full_i;
  assign w_push       = r_issued & ~bus.full_i;
  assign w_advance    = (r_state == RUN) & ~w_stall & ~bus.stop_i;
  assign w_clear      = (r_state == IDLE) & bus.start_i;
  assign w_last_issue = (r_num != '0) && (r_issue_cnt == r_num - COUNT_WIDTH'(1));

`ifdef FUNCT_GEN_AMP_SCALE_EN
  assign w_sample = $signed(bus.read_data_i) >>> bus.amp_shift_i;
`else
  assign w_sample = bus.read_data_i;
`endif

  funct_generator_phase_acc #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_phase_acc (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_advance   (w_advance),
    .i_freq_word (bus.freq_word_i),
    .o_addr      (w_acc_addr)
  );

  // During a stall the LUT must re-read the pending sample so its data stays valid.
  assign bus.read_addr_o = (r_state == IDLE) ? '0 : (w_stall ? r_prev_addr : w_acc_addr);
  assign bus.wr_en_o     = w_push;
  assign bus.wr_data_o   = w_push ? w_sample : '0;
  assign bus.busy_o      = (r_state != IDLE);
  assign bus.done_o      = r_done;

  // Burst control FSM with issue tracking and the registered completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_issued    <= 1'b0;
      r_done      <= 1'b0;
      r_prev_addr <= '0;
      r_issue_cnt <= '0;
      r_num       <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_advance) begin
        r_prev_addr <= w_acc_addr;
        r_issued    <= 1'b1;
        r_issue_cnt <= r_issue_cnt + COUNT_WIDTH'(1);
      end else if (!w_stall) begin
        r_issued <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_state     <= RUN;
            r_issue_cnt <= '0;
            r_num       <= bus.num_samples_i;
          end
        end
        RUN: begin
          if (bus.stop_i || (w_advance && w_last_issue)) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!r_issued || w_push) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_funct_generator_seq.sv
// Self-checking bench for funct_generator_seq: vector table of bursts plus backpressure/stop/reset sequences.
module tb_funct_generator_seq;

  typedef struct packed {
    logic [15:0]       fw;
    logic [15:0]       num;
    logic [0:5][7:0]   addrs;
  } vec_t;

  localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  int          n_tests = 0;
  int          n_fail = 0;
  int          wr_count = 0;
  logic [31:0] sb[$];
  vec_t        vecs[5];

  funct_generator_seq_if bus_if ();

  funct_generator_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lut_val(input logic [7:0] a);
    if (a == 8'h78) return 32'hFFFF_FF00;
    else if (a == 8'hF1) return 32'h0000_0100;
    else return {8'h5A ^ a, a, ~a, a + 8'd1};
  endfunction

  // LUT ROM model: registered read, one cycle of latency.
  always @(posedge clk) bus_if.read_data_i <= lut_val(bus_if.read_addr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // One clock cycle with the given inputs; outputs sampled mid-cycle and writes checked against the scoreboard.
  task automatic step(input logic st, input logic sp, input logic fl);
    logic [31:0] exp;
    @(posedge clk);
    #1;
    bus_if.start_i = st;
    bus_if.stop_i  = sp;
    bus_if.full_i  = fl;
    #3;
    if (bus_if.wr_en_o) begin
      if (sb.size() > 0) exp = sb.pop_front();
      else exp = SENTINEL;
      check("wr_data", bus_if.wr_data_o, exp);
      check("wr_en_while_full", 32'(bus_if.full_i), 32'd0);
      wr_count++;
    end
  endtask

  task automatic run_burst(input vec_t v);
    int rel, first_wr, done_at;
    bus_if.freq_word_i   = v.fw;
    bus_if.num_samples_i = v.num;
    wr_count = 0;
    first_wr = 0;
    done_at  = 0;
    rel      = 0;
    step(1'b1, 1'b0, 1'b0);
    while (done_at == 0 && rel < 40) begin
      step(1'b0, 1'b0, 1'b0);
      rel++;
      if (rel == 1) check("busy_run", 32'(bus_if.busy_o), 32'd1);
      if (rel <= int'(v.num)) check("addr", 32'(bus_if.read_addr_o), 32'(v.addrs[rel-1]));
      if (bus_if.wr_en_o && first_wr == 0) first_wr = rel;
      if (bus_if.done_o) begin
        done_at = rel;
        check("busy_at_done", 32'(bus_if.busy_o), 32'd0);
      end
    end
    check("done_cycle", 32'(done_at), 32'(int'(v.num) + 2));
    check("first_wr_cycle", 32'(first_wr), 32'd2);
    check("wr_count", 32'(wr_count), 32'(v.num));
    check("sb_empty", 32'(sb.size()), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("done_one_cycle", 32'(bus_if.done_o), 32'd0);
  endtask

  initial begin
    int done_at;
    vec_t amp_v;
    vecs[0] = '{fw: 16'h0100, num: 16'd5, addrs: {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0}};
    vecs[1] = '{fw: 16'h4000, num: 16'd6, addrs: {8'd0, 8'd64, 8'd128, 8'd192, 8'd0, 8'd64}};
    vecs[2] = '{fw: 16'h0080, num: 16'd6, addrs: {8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2}};
    vecs[3] = '{fw: 16'hC000, num: 16'd4, addrs: {8'd0, 8'd192, 8'd128, 8'd64, 8'd0, 8'd0}};
    vecs[4] = '{fw: 16'hFFFF, num: 16'd3, addrs: {8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0}};

    rst                  = 1'b1;
    bus_if.start_i       = 1'b0;
    bus_if.stop_i        = 1'b0;
    bus_if.full_i        = 1'b0;
    bus_if.freq_word_i   = 16'h0000;
    bus_if.num_samples_i = 16'd0;
`ifdef FUNCT_GEN_AMP_SCALE_EN
    bus_if.amp_shift_i   = 5'd0;
`endif
    #2;
    check("rst_read_addr", 32'(bus_if.read_addr_o), 32'd0);
    check("rst_wr_en", 32'(bus_if.wr_en_o), 32'd0);
    check("rst_wr_data", bus_if.wr_data_o, 32'd0);
    check("rst_busy", 32'(bus_if.busy_o), 32'd0);
    check("rst_done", 32'(bus_if.done_o), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Mid-burst reset, with a start pulse during RUN that must be ignored.
    bus_if.freq_word_i   = 16'h0100;
    bus_if.num_samples_i = 16'd0;
    wr_count = 0;
    for (int k = 0; k < 3; k++) sb.push_back(lut_val(8'(k)));
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("rs_addr0", 32'(bus_if.read_addr_o), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("start_in_run_ignored", 32'(bus_if.read_addr_o), 32'd2);
    step(1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_read_addr", 32'(bus_if.read_addr_o), 32'd0);
    check("mid_rst_wr_en", 32'(bus_if.wr_en_o), 32'd0);
    check("mid_rst_wr_data", bus_if.wr_data_o, 32'd0);
    check("mid_rst_busy", 32'(bus_if.busy_o), 32'd0);
    check("mid_rst_done", 32'(bus_if.done_o), 32'd0);
    check("rs_wr_count", 32'(wr_count), 32'd3);
    @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < int'(vecs[i].num); k++) sb.push_back(lut_val(vecs[i].addrs[k]));
      run_burst(vecs[i]);
    end

    // Continuous mode, three full cycles while a sample is pending, then stop.
    bus_if.freq_word_i   = 16'h0100;
    bus_if.num_samples_i = 16'd0;
    wr_count = 0;
    for (int k = 0; k < 5; k++) sb.push_back(lut_val(8'(k)));
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      check("stall_addr", 32'(bus_if.read_addr_o), 32'd2);
      check("stall_wr_en", 32'(bus_if.wr_en_o), 32'd0);
    end
    step(1'b0, 1'b0, 1'b0);
    check("release_addr", 32'(bus_if.read_addr_o), 32'd3);
    check("release_wr_en", 32'(bus_if.wr_en_o), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    done_at = 0;
    for (int i = 1; i <= 10 && done_at == 0; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus_if.done_o) done_at = i;
    end
    check("stall_done_cycle", 32'(done_at), 32'd2);
    check("stall_busy_at_done", 32'(bus_if.busy_o), 32'd0);
    check("stall_wr_count", 32'(wr_count), 32'd5);
    check("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Continuous mode, stop together with full: pending sample goes out in DRAIN.
    wr_count = 0;
    sb.push_back(lut_val(8'd0));
    sb.push_back(lut_val(8'd1));
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("stop_stall_wr_en", 32'(bus_if.wr_en_o), 32'd0);
    check("stop_stall_addr", 32'(bus_if.read_addr_o), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    check("drain_busy", 32'(bus_if.busy_o), 32'd1);
    check("drain_wr_en", 32'(bus_if.wr_en_o), 32'd0);
    check("drain_done", 32'(bus_if.done_o), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("drain_push", 32'(bus_if.wr_en_o), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("drain_done_pulse", 32'(bus_if.done_o), 32'd1);
    check("drain_busy_low", 32'(bus_if.busy_o), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("drain_done_clear", 32'(bus_if.done_o), 32'd0);
    check("drain_wr_count", 32'(wr_count), 32'd2);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);

`ifdef FUNCT_GEN_AMP_SCALE_EN
    bus_if.amp_shift_i = 5'd2;
    sb.push_back(32'h1680_3FC0);
    sb.push_back(32'hFFFF_FFC0);
    sb.push_back(32'h0000_0040);
    amp_v = '{fw: 16'h7880, num: 16'd3, addrs: {8'h00, 8'h78, 8'hF1, 8'h00, 8'h00, 8'h00}};
    run_burst(amp_v);
`else
    amp_v = '{fw: 16'h7880, num: 16'd3, addrs: {8'h00, 8'h78, 8'hF1, 8'h00, 8'h00, 8'h00}};
    sb.push_back(lut_val(8'h00));
    sb.push_back(32'hFFFF_FF00);
    sb.push_back(32'h0000_0100);
    run_burst(amp_v);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
